// File: rtl/sr_latch_driver.sv
// Front end for a gated SR latch: synchronises and debounces two buttons, turns their
// rising edges into sequenced s/r/en strobes and flags a latch that fails to follow.
module sr_latch_driver #(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned PULSE_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_rst,
  input  logic q_fb,
  output logic s,
  output logic r,
  output logic en,
  output logic busy,
  output logic err
);

  localparam int unsigned CNT_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned PCNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DB_CYCLES - 1);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PULSE_LEN - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    CHECK  = 3'd4
  } state_t;

  // Bit 0 carries the set button, bit 1 the reset button.
  logic [1:0]       r_meta;
  logic [1:0]       r_sync;
  logic [1:0]       r_db;
  logic [1:0]       r_db_d;
  logic [CNT_W-1:0] r_cnt [2];
  logic [1:0]       w_req;

  state_t            r_state, w_state_nxt;
  logic              r_cmd, w_cmd_nxt;
  logic [PCNT_W-1:0] r_pcnt, w_pcnt_nxt;
  logic              r_s, r_r, r_en, r_busy, r_err;
  logic              w_s_nxt, w_r_nxt, w_en_nxt, w_busy_nxt, w_err_nxt;

  // Synchroniser plus debounce: a level only changes after DB_CYCLES disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_db   <= '0;
      r_db_d <= '0;
      r_cnt  <= '{default: '0};
    end else begin
      r_meta <= {btn_rst, btn_set};
      r_sync <= r_meta;
      r_db_d <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_db[i]  <= r_sync[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_req = r_db & ~r_db_d;

  // Next state, plus output values decoded from the state being entered so they register in step.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_pcnt_nxt  = '0;
    w_err_nxt   = r_err;
    w_s_nxt     = 1'b0;
    w_r_nxt     = 1'b0;
    w_en_nxt    = 1'b0;
    w_busy_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        // Simultaneous requests are a conflict and are both dropped.
        if (w_req[0] ^ w_req[1]) begin
          w_state_nxt = SETUP;
          w_cmd_nxt   = w_req[0];
        end
      end
      SETUP:  w_state_nxt = STROBE;
      STROBE: begin
        if (r_pcnt == PCNT_MAX) w_state_nxt = HOLD;
        else                    w_pcnt_nxt  = r_pcnt + PCNT_W'(1);
      end
      HOLD:   w_state_nxt = CHECK;
      CHECK: begin
        w_state_nxt = IDLE;
        if (q_fb != r_cmd) w_err_nxt = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase

    // s/r stay valid through HOLD so the data outlives the gate edge.
    if (w_state_nxt == SETUP || w_state_nxt == STROBE || w_state_nxt == HOLD) begin
      w_s_nxt = w_cmd_nxt;
      w_r_nxt = ~w_cmd_nxt;
    end
    w_en_nxt   = (w_state_nxt == STROBE);
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cmd   <= 1'b0;
      r_pcnt  <= '0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_s     <= w_s_nxt;
      r_r     <= w_r_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign s    = r_s;
  assign r    = r_r;
  assign en   = r_en;
  assign busy = r_busy;
  assign err  = r_err;

endmodule
